// File: rtl/fp_norm_round.sv
// fp_norm_round: output stage of the binary32 add/sub datapath.
// Normalizes the raw sum from the mantissa adder (carry right-shift or
// leading-zero left-shift), rounds to nearest-even and packs the result.
// Two pipeline stages with valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      upstream handshake
//   in_sign, in_exp          result sign, biased exponent of larger operand
//   in_mant[24:0]            [24]=carry, [23]=hidden bit, [22:0]=fraction
//   in_grs[2:0]              guard, round, sticky from the alignment shift
//   in_nan                   an operand was NaN
//   out_valid / out_ready    downstream handshake
//   out_result[31:0]         packed binary32 result
//   out_flags[2:0]           {overflow, underflow, inexact}, only when
//                            FP_NORM_FLAGS_EN is defined
//
// Optional feature macro: FP_NORM_FLAGS_EN
module fp_norm_round #(
  parameter logic [31:0] NAN_CANON = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  input  logic [2:0]  in_grs,
  input  logic        in_nan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
`ifdef FP_NORM_FLAGS_EN
  ,
  output logic [2:0]  out_flags
`endif
);

  logic adv1, adv2;

  // Stage 1 registers; exponent is 10 bits so carry-out of 254/255 fits
  logic        s1_valid;
  logic        s1_sign;
  logic [9:0]  s1_exp;
  logic [23:0] s1_mant;
  logic        s1_g, s1_r, s1_s;
  logic        s1_nan, s1_inf, s1_zero;
`ifdef FP_NORM_FLAGS_EN
  logic        s1_unf;
`endif

  assign adv2     = !out_valid | out_ready;
  assign adv1     = !s1_valid | adv2;
  assign in_ready = adv1;

  // Leading zeros of in_mant[23:0]; 24 when the field is all zero
  logic [4:0] lzc;
  always_comb begin
    lzc = 5'd24;
    for (int unsigned i = 0; i < 24; i++) begin
      if (in_mant[i]) lzc = 5'(23 - i);
    end
  end

  logic        n_sign;
  logic [9:0]  n_exp;
  logic [23:0] n_mant;
  logic        n_g, n_r, n_s;
  logic        n_inf, n_zero, n_unf;
  logic [25:0] shifted;

  always_comb begin
    n_sign  = in_sign;
    n_exp   = {2'b00, in_exp};
    n_mant  = in_mant[23:0];
    n_g     = in_grs[2];
    n_r     = in_grs[1];
    n_s     = in_grs[0];
    n_inf   = !in_nan && (in_exp == 8'hFF);
    n_zero  = 1'b0;
    n_unf   = 1'b0;
    shifted = '0;
    if (in_mant[24]) begin
      n_mant = in_mant[24:1];
      n_exp  = {2'b00, in_exp} + 10'd1;
      n_g    = in_mant[0];
      n_r    = in_grs[2];
      n_s    = in_grs[1] | in_grs[0];
    end else if (in_mant == 25'd0 && in_grs == 3'd0) begin
      n_zero = 1'b1;
      n_sign = 1'b0;
    end else if (!in_mant[23]) begin
      if ({2'b00, in_exp} > {5'b00000, lzc}) begin
        // {mant, g, r} shift as one field so g then r feed the vacated LSBs;
        // sticky stays in place
        shifted = {in_mant[23:0], in_grs[2], in_grs[1]} << lzc;
        n_mant  = shifted[25:2];
        n_g     = shifted[1];
        n_r     = shifted[0];
        n_exp   = {2'b00, in_exp} - {5'b00000, lzc};
      end else begin
        n_zero = 1'b1;
        n_unf  = 1'b1;
        n_mant = '0;
        n_g    = 1'b0;
        n_r    = 1'b0;
        n_s    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_g     <= 1'b0;
      s1_r     <= 1'b0;
      s1_s     <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
`ifdef FP_NORM_FLAGS_EN
      s1_unf   <= 1'b0;
`endif
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= n_sign;
        s1_exp  <= n_exp;
        s1_mant <= n_mant;
        s1_g    <= n_g;
        s1_r    <= n_r;
        s1_s    <= n_s;
        s1_nan  <= in_nan;
        s1_inf  <= n_inf;
        s1_zero <= n_zero;
`ifdef FP_NORM_FLAGS_EN
        s1_unf  <= n_unf;
`endif
      end
    end
  end

  // Stage 2: round to nearest-even and pack
  logic        inc;
  logic [24:0] sum;
  logic [23:0] r_mant;
  logic [9:0]  r_exp;
  logic        special, ovf;
  logic [31:0] packed_res;

  always_comb begin
    inc     = s1_g & (s1_r | s1_s | s1_mant[0]);
    sum     = {1'b0, s1_mant} + {24'd0, inc};
    r_mant  = sum[24] ? 24'h800000 : sum[23:0];
    r_exp   = s1_exp + {9'd0, sum[24]};
    special = s1_nan | s1_inf;
    ovf     = !special && !s1_zero && (r_exp >= 10'd255);
    if (s1_nan)                   packed_res = NAN_CANON;
    else if (s1_inf || ovf)       packed_res = {s1_sign, 8'hFF, 23'h0};
    else if (s1_zero)             packed_res = {s1_sign, 31'h0};
    else                          packed_res = {s1_sign, r_exp[7:0], r_mant[22:0]};
  end

`ifdef FP_NORM_FLAGS_EN
  logic [2:0] n_flags;
  always_comb begin
    n_flags = '0;
    if (!special) begin
      n_flags[2] = ovf;
      n_flags[1] = s1_unf;
      n_flags[0] = s1_g | s1_r | s1_s | ovf | s1_unf;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
`ifdef FP_NORM_FLAGS_EN
      out_flags  <= '0;
`endif
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= packed_res;
`ifdef FP_NORM_FLAGS_EN
        out_flags  <= n_flags;
`endif
      end
    end
  end

`ifndef FP_NORM_FLAGS_EN
  // Underflow is only reported through out_flags
  logic unused_unf;
  assign unused_unf = n_unf;
`endif

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: directed vector table with latency
// checks, backpressure and mid-stream reset sequences, then randomized
// streaming against an arithmetic reference model.
module tb_fp_norm_round;

  localparam logic [31:0] NAN_CANON = 32'h7FC00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic [2:0]  in_grs;
  logic        in_nan;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
`ifdef FP_NORM_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  always #5 clk = ~clk;

  fp_norm_round #(.NAN_CANON(NAN_CANON)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_grs(in_grs), .in_nan(in_nan),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result)
`ifdef FP_NORM_FLAGS_EN
    , .out_flags(out_flags)
`endif
  );

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mant;
    logic [2:0]  grs;
    logic        nan;
  } stim_t;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  flg;
  } exp_t;

  typedef struct packed {
    stim_t       s;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t  vecs[$];
  stim_t pend[$];
  exp_t  expq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: value-level normalize, nearest-even rounding, pack
  function automatic exp_t model(input stim_t t);
    exp_t            o;
    int              e, lzc, tail;
    longint unsigned keep, wide;
    bit              g, r, s, up;
    o.flg = '0;
    if (t.nan) begin o.res = NAN_CANON; return o; end
    if (t.exp == 8'hFF) begin o.res = {t.sign, 8'hFF, 23'h0}; return o; end
    if (t.mant == 25'd0 && t.grs == 3'd0) begin o.res = '0; return o; end
    e    = int'(t.exp);
    g    = t.grs[2];
    r    = t.grs[1];
    s    = t.grs[0];
    keep = 64'(t.mant);
    if (t.mant[24]) begin
      s    = r | s;
      r    = g;
      g    = t.mant[0];
      keep = keep >> 1;
      e++;
    end else if (!t.mant[23]) begin
      lzc = 0;
      while (lzc < 24 && !t.mant[23 - lzc]) lzc++;
      if (e <= lzc) begin
        o.res = {t.sign, 31'h0};
        o.flg = 3'b011;
        return o;
      end
      wide = ((keep * 4) + 64'(g) * 2 + 64'(r)) << lzc;
      keep = (wide >> 2) & 64'hFFFFFF;
      g    = wide[1];
      r    = wide[0];
      e    = e - lzc;
    end
    tail = (g ? 2 : 0) + ((r | s) ? 1 : 0);
    up   = (tail > 2) || (tail == 2 && keep[0]);
    keep = keep + 64'(up);
    if (keep == 64'h1000000) begin
      keep = keep >> 1;
      e++;
    end
    if (e >= 255) begin
      o.res = {t.sign, 8'hFF, 23'h0};
      o.flg = 3'b101;
      return o;
    end
    o.res = {t.sign, 8'(e), keep[22:0]};
    o.flg = {2'b00, g | r | s};
    return o;
  endfunction

  function automatic vec_t mk(input logic sg, input logic [7:0] ex, input logic [24:0] m,
                              input logic [2:0] grs, input logic nan,
                              input logic [31:0] res, input logic [2:0] flg);
    vec_t v;
    v.s   = '{sign: sg, exp: ex, mant: m, grs: grs, nan: nan};
    v.res = res;
    v.flg = flg;
    return v;
  endfunction

  function automatic stim_t rand_stim();
    stim_t t;
    int unsigned k;
    t.sign = 1'($urandom_range(0, 1));
    t.grs  = 3'($urandom_range(0, 7));
    t.nan  = ($urandom_range(0, 15) == 0);
    k      = $urandom_range(0, 7);
    if (k == 0)      t.exp = 8'(254 + $urandom_range(0, 1));
    else if (k == 1) t.exp = 8'($urandom_range(0, 24));
    else             t.exp = 8'($urandom_range(1, 254));
    case ($urandom_range(0, 3))
      0:       t.mant = {1'b1, 24'($urandom)};
      1:       t.mant = {2'b01, 23'($urandom)};
      2:       t.mant = 25'(24'($urandom) >> $urandom_range(1, 24));
      default: t.mant = 25'($urandom_range(0, 3));
    endcase
    return t;
  endfunction

  task automatic drive(input stim_t t);
    in_sign = t.sign;
    in_exp  = t.exp;
    in_mant = t.mant;
    in_grs  = t.grs;
    in_nan  = t.nan;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input exp_t e);
    check(name, out_result, e.res);
`ifdef FP_NORM_FLAGS_EN
    check({name, "_flags"}, 32'(out_flags), 32'(e.flg));
`endif
  endtask

  // One vector into an empty pipe; result must appear exactly 2 cycles later
  task automatic apply_vec(input vec_t v);
    exp_t e;
    e.res = v.res;
    e.flg = v.flg;
    drive(v.s);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("dir_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("dir_lat1_valid", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("dir_lat2_valid", 32'(out_valid), 32'd1);
    check_out("dir_result", e);
    tick();
  endtask

  // Streams pend[] through the DUT, scoreboarding results in order
  task automatic stream(input int stall, input bit rnd_ready, output int blk_at);
    int          cyc = 0;
    int          acc = 0;
    bit          stalled_prev = 1'b0;
    logic [31:0] held = '0;
    exp_t        e;
    blk_at = -1;
    while ((pend.size() > 0 || expq.size() > 0) && cyc < 4000) begin
      if (pend.size() > 0) begin
        drive(pend[0]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (cyc < stall)    out_ready = 1'b0;
      else if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      else                out_ready = 1'b1;
      @(negedge clk);
      if (stalled_prev && out_valid) check("stall_hold", out_result, held);
      if (in_valid && !in_ready && blk_at < 0) blk_at = acc;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          e = expq.pop_front();
          check_out("stream_result", e);
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(pend[0]));
        void'(pend.pop_front());
        acc++;
      end
      stalled_prev = out_valid && !out_ready;
      held         = out_result;
      tick();
      cyc++;
    end
    if (cyc >= 4000) check("stream_timeout", 32'(expq.size() + pend.size()), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int blk;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive('0);

    vecs.push_back(mk(0, 8'd127, 25'h1000000, 3'b000, 0, 32'h40000000, 3'b000));
    vecs.push_back(mk(0, 8'd127, 25'h0000001, 3'b000, 0, 32'h34000000, 3'b000));
    vecs.push_back(mk(0, 8'd127, 25'h0800000, 3'b100, 0, 32'h3F800000, 3'b001));
    vecs.push_back(mk(0, 8'd127, 25'h0800001, 3'b100, 0, 32'h3F800002, 3'b001));
    vecs.push_back(mk(0, 8'd127, 25'h0FFFFFF, 3'b110, 0, 32'h40000000, 3'b001));
    vecs.push_back(mk(0, 8'd254, 25'h1FFFFFF, 3'b111, 0, 32'h7F800000, 3'b101));
    vecs.push_back(mk(0, 8'd10,  25'h0800000, 3'b000, 1, 32'h7FC00000, 3'b000));
    vecs.push_back(mk(0, 8'd3,   25'h0000010, 3'b000, 0, 32'h00000000, 3'b011));
    vecs.push_back(mk(1, 8'hFF,  25'h0800000, 3'b000, 0, 32'hFF800000, 3'b000));
    vecs.push_back(mk(1, 8'd50,  25'h0000000, 3'b000, 0, 32'h00000000, 3'b000));
    vecs.push_back(mk(1, 8'd3,   25'h0000010, 3'b000, 0, 32'h80000000, 3'b011));
    vecs.push_back(mk(1, 8'd130, 25'h0C00000, 3'b000, 0, 32'hC1400000, 3'b000));
    vecs.push_back(mk(0, 8'd100, 25'h1000003, 3'b000, 0, 32'h32800002, 3'b001));
    vecs.push_back(mk(0, 8'd127, 25'h0400000, 3'b101, 0, 32'h3F000001, 3'b001));
    vecs.push_back(mk(0, 8'd23,  25'h0000001, 3'b000, 0, 32'h00000000, 3'b011));
    vecs.push_back(mk(0, 8'd24,  25'h0000001, 3'b000, 0, 32'h00800000, 3'b000));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    tick();

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Backpressure: 3 stalled cycles, pipe must block after two accepts
    for (int i = 0; i < 4; i++) pend.push_back(vecs[i].s);
    stream(3, 1'b0, blk);
    check("bp_block_after_accepts", 32'(blk), 32'd2);

    // Reset with both stages occupied
    out_ready = 1'b0;
    drive(vecs[0].s);
    in_valid = 1'b1;
    tick();
    drive(vecs[1].s);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_full", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_clear", 32'(out_valid), 32'd0);
    check("rst_async_result", out_result, 32'd0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_no_output", 32'(out_valid), 32'd0);
    tick();
    apply_vec(vecs[3]);

    // Randomized streaming with random backpressure
    for (int i = 0; i < 400; i++) pend.push_back(rand_stim());
    stream(0, 1'b1, blk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
